// File: rtl/dbus_arb_np.sv
// dbus_arb_np - multi-port data-bus arbiter.
//
// Arbitrates NCORES core LSU requests onto NPORTS external synchronous-read
// DMEM ports. Core c is statically mapped to port c % NPORTS, and its local
// index on that port is c / NPORTS. Each port grants round-robin among its
// cores. Two ports writing the same address in one cycle are resolved in favour
// of the lower port. LR/SC reservations follow RISC-V semantics. Read data and
// SC results come back as a 1-cycle rvalid pulse one cycle after acceptance.
//
// Optional feature: define DBUS_RESV_TIMEOUT_EN to give every reservation a
// lifetime of RESV_TIMEOUT cycles. Without it, a reservation lives until it is
// consumed or invalidated.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   re_packed_i/we_packed_i  per-core read/write request (re wins if both)
//   addr_packed_i            per-core word address (DMEM_ADDRW each)
//   wdata_packed_i           per-core write data (32 each)
//   wstrb_packed_i           per-core byte strobes (4 each)
//   is_lr_packed_i           read is LR
//   is_sc_packed_i           write is SC
//   rdata_packed_o           read data or SC result (0 = success)
//   rvalid_packed_o          1-cycle pulse, rdata valid
//   stall_packed_o           request not accepted this cycle
//   mem_re_o/mem_we_o        per-port read/write enables
//   mem_addr_o/mem_wdata_o/mem_wstrb_o  per-port address, data, strobes
//   mem_rdata_i              per-port read data, valid 1 cycle after mem_re_o

`ifndef NCORES
`define NCORES 4
`endif
`ifndef DMEM_ADDRW
`define DMEM_ADDRW 10
`endif

module dbus_arb_np #(
    parameter int unsigned NCORES       = `NCORES,
    parameter int unsigned NPORTS       = 2,
    parameter int unsigned DMEM_ADDRW   = `DMEM_ADDRW,
    parameter int unsigned RESV_TIMEOUT = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NCORES-1:0]            re_packed_i,
    input  logic [NCORES-1:0]            we_packed_i,
    input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
    input  logic [32*NCORES-1:0]         wdata_packed_i,
    input  logic [4*NCORES-1:0]          wstrb_packed_i,
    input  logic [NCORES-1:0]            is_lr_packed_i,
    input  logic [NCORES-1:0]            is_sc_packed_i,
    output logic [32*NCORES-1:0]         rdata_packed_o,
    output logic [NCORES-1:0]            rvalid_packed_o,
    output logic [NCORES-1:0]            stall_packed_o,
    output logic [NPORTS-1:0]            mem_re_o,
    output logic [NPORTS-1:0]            mem_we_o,
    output logic [DMEM_ADDRW*NPORTS-1:0] mem_addr_o,
    output logic [32*NPORTS-1:0]         mem_wdata_o,
    output logic [4*NPORTS-1:0]          mem_wstrb_o,
    input  logic [32*NPORTS-1:0]         mem_rdata_i
);

    // Maximum number of cores sharing one port, and derived widths.
    localparam int unsigned LPP = (NCORES + NPORTS - 1) / NPORTS;
    localparam int unsigned PW  = (LPP > 1) ? $clog2(LPP) : 1;
    localparam int unsigned CW  = (NCORES > 1) ? $clog2(NCORES) : 1;

    function automatic int unsigned cores_on_port(input int unsigned p);
        return (NCORES - p + NPORTS - 1) / NPORTS;
    endfunction

    logic [NCORES-1:0]     req;
    logic [NCORES-1:0]     accepted;

    // Per-port grant and decode
    logic [NPORTS-1:0]     g_vld, g_re, g_we, g_lr, g_sc;
    logic [NPORTS-1:0]     sc_ok, wr_mem, revoke, acc;
    logic [CW-1:0]         g_core [NPORTS];
    logic [PW-1:0]         g_next [NPORTS];
    logic [DMEM_ADDRW-1:0] g_addr [NPORTS];

    // Round-robin pointers (local index per port)
    logic [PW-1:0]         rr_q [NPORTS];
    logic [PW-1:0]         rr_d [NPORTS];

    // Pending responses, one per port
    logic [NPORTS-1:0]     rsp_vld_q, rsp_vld_d;
    logic [NPORTS-1:0]     rsp_sc_q, rsp_sc_d;
    logic [NPORTS-1:0]     rsp_fail_q, rsp_fail_d;
    logic [CW-1:0]         rsp_core_q [NPORTS];
    logic [CW-1:0]         rsp_core_d [NPORTS];

    // Reservations
    logic [NCORES-1:0]     resv_vld_q, resv_vld_d;
    logic [DMEM_ADDRW-1:0] resv_addr_q [NCORES];
    logic [DMEM_ADDRW-1:0] resv_addr_d [NCORES];
    logic [NCORES-1:0]     resv_live;

`ifdef DBUS_RESV_TIMEOUT_EN
    localparam int unsigned CNTW = $clog2(RESV_TIMEOUT + 1);
    logic [CNTW-1:0]       cnt_q [NCORES];
    logic [CNTW-1:0]       cnt_d [NCORES];

    // A reservation whose counter has reached zero no longer satisfies an SC.
    always_comb begin
        for (int unsigned c = 0; c < NCORES; c++) begin
            resv_live[c] = resv_vld_q[c] & (cnt_q[c] != '0);
        end
    end
`else
    assign resv_live = resv_vld_q;
`endif

    assign req = re_packed_i | we_packed_i;

    // ------------------------------------------------------------------
    // Round-robin arbitration per port
    // ------------------------------------------------------------------
    always_comb begin
        int unsigned n, l, c;
        n = 0;
        l = 0;
        c = 0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            g_vld[p]  = 1'b0;
            g_core[p] = '0;
            g_next[p] = '0;
            n = cores_on_port(p);
            for (int unsigned i = 0; i < LPP; i++) begin
                if (i < n) begin
                    // rr pointer is always < n, so one wrap suffices
                    l = 32'(rr_q[p]) + i;
                    if (l >= n) l = l - n;
                    c = l * NPORTS + p;
                    if (!g_vld[p] && req[CW'(c)]) begin
                        g_vld[p]  = 1'b1;
                        g_core[p] = CW'(c);
                        g_next[p] = (l + 1 >= n) ? '0 : PW'(l + 1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant decode, SC evaluation, write-write conflict resolution
    // ------------------------------------------------------------------
    always_comb begin
        logic [CW-1:0] gc;
        gc = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            gc        = g_core[p];
            g_re[p]   = g_vld[p] & re_packed_i[gc];
            g_we[p]   = g_vld[p] & we_packed_i[gc] & ~re_packed_i[gc];
            g_lr[p]   = g_re[p] & is_lr_packed_i[gc];
            g_sc[p]   = g_we[p] & is_sc_packed_i[gc];
            g_addr[p] = addr_packed_i[32'(gc)*DMEM_ADDRW +: DMEM_ADDRW];
            // Uses registered reservation state only
            sc_ok[p]  = g_sc[p] & resv_live[gc] & (resv_addr_q[gc] == g_addr[p]);
            wr_mem[p] = g_we[p] & (~g_sc[p] | sc_ok[p]);
        end
        // Comparing against every lower port's raw write is enough: if a lower
        // port is itself revoked, its own winner has the same address too.
        for (int unsigned p = 0; p < NPORTS; p++) begin
            revoke[p] = 1'b0;
            for (int unsigned q = 0; q < p; q++) begin
                if (wr_mem[q] && wr_mem[p] && (g_addr[q] == g_addr[p])) begin
                    revoke[p] = 1'b1;
                end
            end
            // Nothing is accepted while reset is asserted, so memory goes idle
            acc[p] = g_vld[p] & ~revoke[p] & rst_ni;
        end
    end

    assign mem_re_o = acc & g_re;
    assign mem_we_o = acc & wr_mem;

    // ------------------------------------------------------------------
    // Core-side and memory-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        accepted        = '0;
        rvalid_packed_o = '0;
        rdata_packed_o  = '0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        mem_wstrb_o     = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (acc[p]) begin
                accepted[g_core[p]] = 1'b1;
            end
            if (mem_re_o[p] || mem_we_o[p]) begin
                mem_addr_o[p*DMEM_ADDRW +: DMEM_ADDRW] = g_addr[p];
            end
            if (mem_we_o[p]) begin
                mem_wdata_o[p*32 +: 32] = wdata_packed_i[32'(g_core[p])*32 +: 32];
                mem_wstrb_o[p*4 +: 4]   = wstrb_packed_i[32'(g_core[p])*4 +: 4];
            end
            if (rsp_vld_q[p]) begin
                rvalid_packed_o[rsp_core_q[p]] = 1'b1;
                rdata_packed_o[32'(rsp_core_q[p])*32 +: 32] =
                    rsp_sc_q[p] ? {31'b0, rsp_fail_q[p]} : mem_rdata_i[p*32 +: 32];
            end
        end
        stall_packed_o = req & ~accepted;
    end

    // ------------------------------------------------------------------
    // Next state: pointers, responses, reservations
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned p = 0; p < NPORTS; p++) begin
            rr_d[p]       = acc[p] ? g_next[p] : rr_q[p];
            rsp_core_d[p] = g_core[p];
        end
        rsp_vld_d  = acc & (g_re | g_sc);
        rsp_sc_d   = g_sc;
        rsp_fail_d = ~sc_ok;
    end

    always_comb begin
        resv_vld_d  = resv_vld_q;
        resv_addr_d = resv_addr_q;
`ifdef DBUS_RESV_TIMEOUT_EN
        cnt_d = cnt_q;
        for (int unsigned c = 0; c < NCORES; c++) begin
            if (resv_vld_q[c]) begin
                if (cnt_q[c] == '0) resv_vld_d[c] = 1'b0;
                else                cnt_d[c]      = cnt_q[c] - CNTW'(1);
            end
        end
`endif
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (acc[p] && g_sc[p]) begin
                resv_vld_d[g_core[p]] = 1'b0;
            end
            if (acc[p] && g_lr[p]) begin
                resv_vld_d[g_core[p]]  = 1'b1;
                resv_addr_d[g_core[p]] = g_addr[p];
`ifdef DBUS_RESV_TIMEOUT_EN
                cnt_d[g_core[p]] = CNTW'(RESV_TIMEOUT);
`endif
            end
        end
        // Invalidation runs after LR capture so a same-cycle matching write wins
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (mem_we_o[p]) begin
                for (int unsigned c = 0; c < NCORES; c++) begin
                    if (resv_addr_d[c] == g_addr[p]) resv_vld_d[c] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_q  <= '0;
            rsp_sc_q   <= '0;
            rsp_fail_q <= '0;
            resv_vld_q <= '0;
            for (int unsigned p = 0; p < NPORTS; p++) begin
                rr_q[p]       <= '0;
                rsp_core_q[p] <= '0;
            end
            for (int unsigned c = 0; c < NCORES; c++) begin
                resv_addr_q[c] <= '0;
`ifdef DBUS_RESV_TIMEOUT_EN
                cnt_q[c] <= '0;
`endif
            end
        end else begin
            rsp_vld_q   <= rsp_vld_d;
            rsp_sc_q    <= rsp_sc_d;
            rsp_fail_q  <= rsp_fail_d;
            resv_vld_q  <= resv_vld_d;
            rr_q        <= rr_d;
            rsp_core_q  <= rsp_core_d;
            resv_addr_q <= resv_addr_d;
`ifdef DBUS_RESV_TIMEOUT_EN
            cnt_q <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dbus_arb_np.sv
module tb_dbus_arb_np;

    localparam int unsigned NC = 4;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 10;
    localparam int unsigned TO = 4;
`ifdef DBUS_RESV_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC-1:0]     re, we, is_lr, is_sc;
    logic [AW*NC-1:0]  addr;
    logic [32*NC-1:0]  wdata;
    logic [4*NC-1:0]   wstrb;
    logic [32*NC-1:0]  rdata;
    logic [NC-1:0]     rvalid, stall;
    logic [NP-1:0]     mem_re, mem_we;
    logic [AW*NP-1:0]  mem_addr;
    logic [32*NP-1:0]  mem_wdata;
    logic [4*NP-1:0]   mem_wstrb;
    logic [32*NP-1:0]  mem_rdata;

    dbus_arb_np #(
        .NCORES(NC), .NPORTS(NP), .DMEM_ADDRW(AW), .RESV_TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .re_packed_i(re), .we_packed_i(we),
        .addr_packed_i(addr), .wdata_packed_i(wdata), .wstrb_packed_i(wstrb),
        .is_lr_packed_i(is_lr), .is_sc_packed_i(is_sc),
        .rdata_packed_o(rdata), .rvalid_packed_o(rvalid), .stall_packed_o(stall),
        .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Shared synchronous-read memory model (read-before-write)
    logic [31:0] mem [1<<AW];
    logic [31:0] rd_q [NP];

    always @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (mem_re[p]) rd_q[p] <= mem[mem_addr[p*AW +: AW]];
            if (mem_we[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[p*4 + b])
                        mem[mem_addr[p*AW +: AW]][b*8 +: 8] <= mem_wdata[p*32 + b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) mem_rdata[p*32 +: 32] = rd_q[p];
    end

    // Scoreboard
    typedef struct {
        int unsigned core;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic expect_rsp(input int unsigned c, input logic [31:0] d);
        exp_t e;
        e.core = c;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: pop one expectation per rvalid pulse
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int c = 0; c < NC; c++) begin
                if (rvalid[c]) begin
                    n_chk++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_unexpected: core %0d data %h, none expected", c, rdata[c*32 +: 32]);
                    end else begin
                        e = sb.pop_front();
                        if (e.core != c || e.data !== rdata[c*32 +: 32]) begin
                            n_fail++;
                            $display("FAIL rsp: got core %0d data %h expected core %0d data %h",
                                     c, rdata[c*32 +: 32], e.core, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        re = '0; we = '0; is_lr = '0; is_sc = '0;
    endtask

    task automatic rd(input int c, input logic [AW-1:0] a, input bit lr);
        re[c] = 1'b1; we[c] = 1'b0; is_lr[c] = lr; is_sc[c] = 1'b0;
        addr[c*AW +: AW] = a;
    endtask

    task automatic wr(input int c, input logic [AW-1:0] a, input logic [31:0] d, input bit sc);
        re[c] = 1'b0; we[c] = 1'b1; is_lr[c] = 1'b0; is_sc[c] = sc;
        addr[c*AW +: AW] = a; wdata[c*32 +: 32] = d; wstrb[c*4 +: 4] = 4'hF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | 32'(i);
        for (int p = 0; p < NP; p++) rd_q[p] = '0;
        idle_all();
        addr = '0; wdata = '0; wstrb = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", rdata[31:0], 32'h0);
        chk("rst_mem_re", 32'(mem_re), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Pointer starts at local 0: core 1 beats core 3 on port 1
        rd(1, 10'h001, 1'b0); rd(3, 10'h003, 1'b0);
        @(negedge clk);
        chk("rr0_stall", 32'(stall), 32'b1000);
        expect_rsp(1, 32'hA000_0001);
        step();
        re[1] = 1'b0;
        @(negedge clk);
        chk("rr1_stall", 32'(stall), 32'b0000);
        expect_rsp(3, 32'hA000_0003);
        step();
        idle_all();

        // Cores 0 and 2 read on port 0 simultaneously
        rd(0, 10'h010, 1'b0); rd(2, 10'h020, 1'b0);
        @(negedge clk);
        chk("t1_stall0", 32'(stall), 32'b0100);
        chk("t1_mem_re", 32'(mem_re), 32'b01);
        chk("t1_addr", 32'(mem_addr[AW-1:0]), 32'h010);
        expect_rsp(0, 32'hA000_0010);
        step();
        re[0] = 1'b0;
        @(negedge clk);
        chk("t1_stall1", 32'(stall), 32'b0000);
        expect_rsp(2, 32'hA000_0020);
        step();
        idle_all();

        // LR then SC succeeds, second SC fails
        rd(1, 10'h040, 1'b1);
        expect_rsp(1, 32'hA000_0040);
        step();
        wr(1, 10'h040, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        chk("t2_sc_we", 32'(mem_we), 32'b10);
        chk("t2_sc_wdata", mem_wdata[63:32], 32'hDEAD_BEEF);
        expect_rsp(1, 32'h0);
        step();
        @(negedge clk);
        chk("t2_sc2_we", 32'(mem_we), 32'b00);
        chk("t2_sc2_stall", 32'(stall), 32'b0000);
        expect_rsp(1, 32'h1);
        step();
        idle_all();
        rd(3, 10'h040, 1'b0);
        expect_rsp(3, 32'hDEAD_BEEF);
        step();
        idle_all();

        // LR, other core's write invalidates, SC fails
        rd(1, 10'h040, 1'b1);
        expect_rsp(1, 32'hDEAD_BEEF);
        step();
        idle_all();
        wr(0, 10'h040, 32'h1234_5678, 1'b0);
        @(negedge clk);
        chk("t3_wr_we", 32'(mem_we), 32'b01);
        step();
        idle_all();
        wr(1, 10'h040, 32'hCAFE_F00D, 1'b1);
        @(negedge clk);
        chk("t3_sc_we", 32'(mem_we), 32'b00);
        expect_rsp(1, 32'h1);
        step();
        idle_all();
        rd(3, 10'h040, 1'b0);
        expect_rsp(3, 32'h1234_5678);
        step();
        idle_all();

        // Write-write conflict: port 0 wins, core 1 retries
        wr(0, 10'h080, 32'h1111_2222, 1'b0); wr(1, 10'h080, 32'h3333_4444, 1'b0);
        @(negedge clk);
        chk("t4_we_a", 32'(mem_we), 32'b01);
        chk("t4_stall_a", 32'(stall), 32'b0010);
        step();
        we[0] = 1'b0;
        @(negedge clk);
        chk("t4_we_b", 32'(mem_we), 32'b10);
        chk("t4_stall_b", 32'(stall), 32'b0000);
        step();
        idle_all();
        rd(2, 10'h080, 1'b0);
        expect_rsp(2, 32'h3333_4444);
        step();
        idle_all();

        // LR and matching write in the same cycle: reservation ends invalid
        rd(0, 10'h050, 1'b1); wr(1, 10'h050, 32'h5555_6666, 1'b0);
        @(negedge clk);
        chk("t5_re", 32'(mem_re), 32'b01);
        chk("t5_we", 32'(mem_we), 32'b10);
        expect_rsp(0, 32'hA000_0050);
        step();
        idle_all();
        wr(0, 10'h050, 32'h7777_8888, 1'b1);
        @(negedge clk);
        chk("t5_sc_we", 32'(mem_we), 32'b00);
        expect_rsp(0, 32'h1);
        step();
        idle_all();

        // Reservation lifetime: SC 3 cycles after LR
        rd(1, 10'h060, 1'b1);
        expect_rsp(1, 32'hA000_0060);
        step();
        idle_all();
        step();
        step();
        wr(1, 10'h060, 32'h0000_0060, 1'b1);
        @(negedge clk);
        chk("t6_sc3_we", 32'(mem_we), 32'b10);
        expect_rsp(1, 32'h0);
        step();
        idle_all();

        // SC 5 cycles after a fresh LR
        rd(1, 10'h061, 1'b1);
        expect_rsp(1, 32'hA000_0061);
        step();
        idle_all();
        step();
        step();
        step();
        step();
        wr(1, 10'h061, 32'h0000_0061, 1'b1);
        @(negedge clk);
        chk("t6_sc5_we", 32'(mem_we), TO_EN ? 32'b00 : 32'b10);
        expect_rsp(1, TO_EN ? 32'h1 : 32'h0);
        step();
        idle_all();

        // Reset mid-read drops rvalid and idles memory immediately
        rd(0, 10'h010, 1'b0);
        @(negedge clk);
        chk("t7_re", 32'(mem_re), 32'b01);
        step();
        chk("t7_rvalid_pre", 32'(rvalid), 32'b0001);
        rst_n = 1'b0;
        #1;
        chk("t7_rvalid_rst", 32'(rvalid), 32'b0000);
        chk("t7_mem_re_rst", 32'(mem_re), 32'b00);
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;
        step();

        // After reset the port-0 pointer is back at core 0
        rd(0, 10'h010, 1'b0); rd(2, 10'h020, 1'b0);
        @(negedge clk);
        chk("t7_post_stall", 32'(stall), 32'b0100);
        expect_rsp(0, 32'hA000_0010);
        step();
        idle_all();
        repeat (3) step();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dbus_arb_np.md
Name: dbus_arb_np

Overview:
- Parametrised successor to the two-port combinational data-bus arbiter. Arbitrates NCORES core data requests onto NPORTS external synchronous-read DMEM ports.
- Provides per-port round-robin, LR/SC reservations with RISC-V semantics, and explicit read-valid returns.
- Sits between the cores' LSU buses and a multi-port DMEM wrapper. The memory is external, so the bench can model it.

Parameters:
- NCORES, `NCORES, number of cores (>=1).
- NPORTS, 2, number of DMEM ports (1..NCORES).
- DMEM_ADDRW, `DMEM_ADDRW, word-address width.
- RESV_TIMEOUT, 64, reservation lifetime in cycles. Used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- re_packed_i  in  NCORES  per-core read request.
- we_packed_i  in  NCORES  per-core write request.
- addr_packed_i  in  DMEM_ADDRW*NCORES  per-core word address.
- wdata_packed_i  in  32*NCORES  per-core write data.
- wstrb_packed_i  in  4*NCORES  per-core byte strobes.
- is_lr_packed_i  in  NCORES  read is LR.
- is_sc_packed_i  in  NCORES  write is SC.
- rdata_packed_o  out  32*NCORES  returned data or SC result.
- rvalid_packed_o  out  NCORES  1-cycle pulse, rdata valid.
- stall_packed_o  out  NCORES  request not accepted this cycle.
- mem_re_o  out  NPORTS  port read enable.
- mem_we_o  out  NPORTS  port write enable.
- mem_addr_o  out  DMEM_ADDRW*NPORTS  port address.
- mem_wdata_o  out  32*NPORTS  port write data.
- mem_wstrb_o  out  4*NPORTS  port strobes.
- mem_rdata_i  in  32*NPORTS  port read data, valid 1 cycle after mem_re_o.

Behaviour:
- Reset (async assert, sync deassert):
  - All reservations invalid.
  - All RR pointers = 0.
  - rvalid/rdata = 0.
  - Timeout counters = 0.
- Core mapping: core c is statically on port p = c % NPORTS. Local index is c / NPORTS.
- Request: req[c] = re|we. If re and we are both high, it is treated as a read.
- Arbitration (combinational, same cycle):
  - Each port grants the first requesting core at or after rr_ptr[p] in local order.
  - rr_ptr[p] <= granted local index + 1 (mod cores on port) only when the grant is accepted. Otherwise it holds.
- Write-write conflict: when two ports both grant writes (incl. successful SC) to the same address in one cycle, the lowest port wins. Each losing port's grant is revoked that cycle: core stalled, mem_* idle, pointer not advanced.
- stall[c] = req[c] & ~accepted[c]. The core holds its request stable while stalled.
- Accepted read:
  - mem_re_o[p] = 1 with the address.
  - Next cycle: rdata[c] = mem_rdata_i[p], rvalid[c] = 1.
  - All other rdata = 0.
- Accepted LR: as a read, plus reservation[c] <= {1, addr}.
- Accepted plain write: mem_we_o[p] = 1 with data and strobes.
- Accepted SC:
  - Success iff reservation[c] valid and the address matches. On success, mem_we_o[p] = 1; on failure, no memory write.
  - Next cycle: rdata[c] = 0 on success, 1 on failure; rvalid[c] = 1.
  - reservation[c] is cleared in both cases.
- Plain writes produce no rvalid.
- Invalidation: every accepted memory write (any port) clears all reservations whose address equals the write address, in the same cycle.
  - If an LR and a matching write are accepted in the same cycle, invalidation wins: the reservation ends invalid.
- Reservation validity is decided from registered state only. An SC and another port's write to the same address in the same cycle: SC is evaluated against the pre-write state. Both writes then go through the write-write conflict rule.
- Latency: read/SC result exactly 1 cycle after acceptance. Back-to-back accepts on one port give an rvalid every cycle.
- Reset mid-transaction: pending rvalid is dropped, and memory outputs go idle immediately.

Optional Feature:
- Macro: DBUS_RESV_TIMEOUT_EN.
- When defined, each core has a counter that loads RESV_TIMEOUT on LR acceptance and decrements while the reservation is valid. At 0 the reservation is cleared, and an SC in the cycle the counter reaches 0 fails.
- When undefined, there are no counters, RESV_TIMEOUT is unused, and reservations live until invalidated.

Test Plan (NCORES=4, NPORTS=2):
- Cores 0 and 2 read 0x10 and 0x20 simultaneously, held for 2 cycles.
  - Cycle 0: core 0 accepted, core 2 stalled.
  - Cycle 1: core 2 accepted, with rvalid[0] carrying mem[0x10].
  - Cycle 2: rvalid[2] carries mem[0x20].
- Core 1: LR 0x40, then SC 0x40 data 0xDEADBEEF.
  - SC result 0; mem[0x40] = 0xDEADBEEF.
  - A second SC returns 1 with no write.
- Core 1 LR 0x40; core 0 writes 0x40; then core 1 SC 0x40 → result 1, mem_we_o[1] stays 0.
- Cores 0 and 1 write 0x80 in the same cycle → port 0 writes, core 1 stalls one cycle, then writes.
- Core 0 LR 0x50 while core 1 writes 0x50 in the same cycle; then core 0 SC 0x50 → fails (1).
- With DBUS_RESV_TIMEOUT_EN and RESV_TIMEOUT=4:
  - SC at 3 cycles after LR → 0.
  - SC at 5 cycles after a fresh LR → 1.
  - Assert rst_ni low mid-read → rvalid = 0 immediately.
